uart_cmd_rx: RTL and testbench

Serial front end for the command path. Receives 8N1 UART bytes on `RX` and assembles three of them, MSB first, into a 24-bit command. It presents that command as `cmd`/`cmd_rdy` to the command-config stage. It also relays that stage's single-byte response (`send_resp`/`resp_data`) to an external UART transmitter and returns `resp_sent` when the transmitter finishes.

---
 rtl/uart_cmd_rx_pkg.sv | 34 +++
 rtl/uart_rx_core.sv | 120 ++++++++++++
 rtl/uart_cmd_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_rx_pkg
//  Description : Shared command-path types and constants. Holds the
//                assembler, response and receiver state encodings, plus
//                the standard acknowledge byte values.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_rx_pkg;

    typedef enum logic [1:0] {
        B0   = 2'd0,
        B1   = 2'd1,
        B2   = 2'd2,
        HOLD = 2'd3
    } asm_state_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } resp_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic [7:0] POS_ACK = 8'hA5;
    localparam logic [7:0] NEG_ACK = 8'hEE;

endpackage : uart_cmd_rx_pkg
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core
//  Description : 8N1 UART byte receiver. Two-flop synchronizer, falling-edge
//                start detect, mid-bit sampling using a down-counting baud
//                counter. Produces a one-cycle rx_rdy with rx_byte on a good
//                stop bit, or a one-cycle frm_err on a low stop bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import uart_cmd_rx_pkg::*;
#(
    parameter int BAUD_DIV = 1302
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       rx_rdy,
    output logic [7:0] rx_byte,
    output logic       frm_err
);

    localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);

    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_prev_q;
    rx_state_t        state_q;
    logic [CNT_W-1:0] baud_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             rdy_q;
    logic             frm_q;
    logic             w_fall;

    // Synchronize RX into the clk domain; flops preset high so reset never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign w_fall = rx_prev_q & ~rx_sync_q;

    // Frame FSM: half-bit to the start-bit centre, then full bits for data and stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            rdy_q   <= 1'b0;
            frm_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            frm_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (w_fall) begin
                        state_q <= RX_START;
                        baud_q  <= HALF_LOAD;
                    end
                end
                RX_START: begin
                    if (baud_q == '0) begin
                        // A high start-bit sample is a glitch: abort silently
                        if (rx_sync_q) begin
                            state_q <= RX_IDLE;
                        end else begin
                            state_q <= RX_DATA;
                            baud_q  <= FULL_LOAD;
                            bit_q   <= 3'd0;
                        end
                    end else begin
                        baud_q <= baud_q - CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (baud_q == '0) begin
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        baud_q  <= FULL_LOAD;
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        baud_q <= baud_q - CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (baud_q == '0) begin
                        if (rx_sync_q) begin
                            rdy_q <= 1'b1;
                        end else begin
                            frm_q <= 1'b1;
                        end
                        state_q <= RX_IDLE;
                    end else begin
                        baud_q <= baud_q - CNT_W'(1);
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_rdy  = rdy_q;
    assign rx_byte = shift_q;
    assign frm_err = frm_q;

endmodule : uart_rx_core
`default_nettype wire

// File: rtl/uart_cmd_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_rx
//  Description : UART command front end. Assembles three received bytes
//                (MSB first) into a 24-bit command held until cleared, and
//                relays a one-byte response to an external transmitter.
//                Optional inter-byte timeout enabled by CMD_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int BAUD_DIV    = 1302,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp_data,
    input  logic        tx_done,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    output logic        trmt,
    output logic [7:0]  tx_data,
    output logic        resp_sent,
    output logic        ovr_err,
    output logic        frm_err
);

    logic        w_rx_rdy;
    logic [7:0]  w_rx_byte;
    logic        w_timeout;

    asm_state_t  asm_q;
    logic [23:0] cmd_q;
    logic        cmd_rdy_q;
    logic        ovr_err_q;

    resp_state_t resp_q;
    logic        trmt_q;
    logic [7:0]  tx_data_q;
    logic        resp_sent_q;

    uart_rx_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .rx_rdy  (w_rx_rdy),
        .rx_byte (w_rx_byte),
        .frm_err (frm_err)
    );

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] idle_cnt_q;
    logic            w_mid_cmd;

    assign w_mid_cmd = (asm_q == B1) || (asm_q == B2);
    assign w_timeout = w_mid_cmd && (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    // Idle counter between bytes of one command; every entry to B1/B2 comes with rx_rdy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
        end else if (w_rx_rdy || !w_mid_cmd || w_timeout) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + TO_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Command assembler: B0/B1/B2 capture bytes, HOLD keeps the command until cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q     <= B0;
            cmd_q     <= 24'd0;
            cmd_rdy_q <= 1'b0;
            ovr_err_q <= 1'b0;
        end else begin
            ovr_err_q <= 1'b0;
            case (asm_q)
                B0: begin
                    if (w_rx_rdy) begin
                        cmd_q[23:16] <= w_rx_byte;
                        asm_q        <= B1;
                    end
                end
                B1, B2: begin
                    // On a timeout the partial command is abandoned; a byte landing now starts afresh
                    if (w_timeout) begin
                        if (w_rx_rdy) begin
                            cmd_q[23:16] <= w_rx_byte;
                            asm_q        <= B1;
                        end else begin
                            asm_q <= B0;
                        end
                    end else if (w_rx_rdy) begin
                        if (asm_q == B1) begin
                            cmd_q[15:8] <= w_rx_byte;
                            asm_q       <= B2;
                        end else begin
                            cmd_q[7:0] <= w_rx_byte;
                            cmd_rdy_q  <= 1'b1;
                            asm_q      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (clr_cmd_rdy) begin
                        cmd_rdy_q <= 1'b0;
                        if (w_rx_rdy) begin
                            cmd_q[23:16] <= w_rx_byte;
                            asm_q        <= B1;
                        end else begin
                            asm_q <= B0;
                        end
                    end else if (w_rx_rdy) begin
                        ovr_err_q <= 1'b1;
                    end
                end
                default: asm_q <= B0;
            endcase
        end
    end

    // Response relay: latch the byte, pulse trmt, wait for tx_done, pulse resp_sent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q      <= IDLE;
            trmt_q      <= 1'b0;
            tx_data_q   <= 8'd0;
            resp_sent_q <= 1'b0;
        end else begin
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
            case (resp_q)
                IDLE: begin
                    if (send_resp) begin
                        tx_data_q <= resp_data;
                        trmt_q    <= 1'b1;
                        resp_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (tx_done) begin
                        resp_sent_q <= 1'b1;
                        resp_q      <= IDLE;
                    end
                end
                default: resp_q <= IDLE;
            endcase
        end
    end

    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign ovr_err   = ovr_err_q;
    assign trmt      = trmt_q;
    assign tx_data   = tx_data_q;
    assign resp_sent = resp_sent_q;

endmodule : uart_cmd_rx
`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_cmd_rx
//  Description : Self-checking bench for uart_cmd_rx. Table of directed byte
//                transfers, hand sequences for response, inter-byte wait and
//                reset, then random bytes checked against a command model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_rx;
    import uart_cmd_rx_pkg::*;

    localparam int c_BAUD = 16;
    localparam int c_TO   = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RX;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp_data;
    logic        tx_done;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        resp_sent;
    logic        ovr_err;
    logic        frm_err;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    int frm_cnt = 0;
    int trmt_cnt = 0;
    int sent_cnt = 0;

    // reference model of the command assembler
    bit          m_pending;
    int          m_idx;
    logic [23:0] m_cmd;

    typedef struct {
        logic [7:0]  data;
        bit          stop_ok;
        bit          clr;
        logic [23:0] exp_cmd;
        bit          exp_rdy;
        int          exp_ovr;
        int          exp_frm;
    } vec_t;

    vec_t tbl[11];

    uart_cmd_rx #(
        .BAUD_DIV    (c_BAUD),
        .TIMEOUT_CYC (c_TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .clr_cmd_rdy (clr_cmd_rdy),
        .send_resp   (send_resp),
        .resp_data   (resp_data),
        .tx_done     (tx_done),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .resp_sent   (resp_sent),
        .ovr_err     (ovr_err),
        .frm_err     (frm_err)
    );

    always #5 clk = ~clk;

    // count high cycles of the pulse outputs; single-cycle pulses make this a pulse count
    always @(negedge clk) begin
        if (ovr_err === 1'b1)   ovr_cnt++;
        if (frm_err === 1'b1)   frm_cnt++;
        if (trmt === 1'b1)      trmt_cnt++;
        if (resp_sent === 1'b1) sent_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        RX = 1'b0;
        repeat (c_BAUD) tick();
        for (int k = 0; k < 8; k++) begin
            RX = b[k];
            repeat (c_BAUD) tick();
        end
        RX = stop_ok ? 1'b1 : 1'b0;
        repeat (c_BAUD) tick();
        RX = 1'b1;
        repeat (6) tick();
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
    endtask

    // model: one clear request (ignored unless a command is pending)
    task automatic model_clr();
        if (m_pending) begin
            m_pending = 1'b0;
            m_idx     = 0;
        end
    endtask

    // model: one received frame; returns expected overrun/framing increments
    task automatic model_byte(input logic [7:0] b, input bit stop_ok, output int d_ovr, output int d_frm);
        int sh;
        d_ovr = 0;
        d_frm = 0;
        if (!stop_ok) begin
            d_frm = 1;
        end else if (m_pending) begin
            d_ovr = 1;
        end else begin
            sh    = 8 * (2 - m_idx);
            m_cmd = (m_cmd & ~(24'hFF << sh)) | (24'(b) << sh);
            m_idx = m_idx + 1;
            if (m_idx == 3) begin
                m_pending = 1'b1;
                m_idx     = 0;
            end
        end
    endtask

    initial begin
        int o0, f0, d_ovr, d_frm;
        logic [7:0] rb;
        bit rs, rc;

        tbl[0]  = '{8'h06, 1'b1, 1'b0, 24'h060000, 1'b0, 0, 0};
        tbl[1]  = '{8'h2A, 1'b1, 1'b0, 24'h062A00, 1'b0, 0, 0};
        tbl[2]  = '{8'h05, 1'b1, 1'b0, 24'h062A05, 1'b1, 0, 0};
        tbl[3]  = '{8'h77, 1'b1, 1'b0, 24'h062A05, 1'b1, 1, 0};
        tbl[4]  = '{8'h09, 1'b1, 1'b1, 24'h092A05, 1'b0, 0, 0};
        tbl[5]  = '{8'h10, 1'b1, 1'b0, 24'h091005, 1'b0, 0, 0};
        tbl[6]  = '{8'h00, 1'b1, 1'b0, 24'h091000, 1'b1, 0, 0};
        tbl[7]  = '{8'h55, 1'b0, 1'b1, 24'h091000, 1'b0, 0, 1};
        tbl[8]  = '{8'h01, 1'b1, 1'b0, 24'h011000, 1'b0, 0, 0};
        tbl[9]  = '{8'h02, 1'b1, 1'b0, 24'h010200, 1'b0, 0, 0};
        tbl[10] = '{8'h03, 1'b1, 1'b0, 24'h010203, 1'b1, 0, 0};

        rst_n       = 1'b0;
        RX          = 1'b1;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        resp_data   = 8'h00;
        tx_done     = 1'b0;
        repeat (3) tick();
        check("rst_cmd", 32'(cmd), 32'h0);
        check("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
        check("rst_trmt", 32'(trmt), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_resp_sent", 32'(resp_sent), 32'h0);
        check("rst_ovr_err", 32'(ovr_err), 32'h0);
        check("rst_frm_err", 32'(frm_err), 32'h0);
        rst_n = 1'b1;
        repeat (4) tick();

        // directed table: assembly, overrun, clear, framing error
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].clr) begin
                pulse_clr();
                check($sformatf("clr_rdy[%0d]", i), 32'(cmd_rdy), 32'h0);
                check($sformatf("clr_cmd_kept[%0d]", i), 32'(cmd), 32'(tbl[i-1].exp_cmd));
            end
            o0 = ovr_cnt;
            f0 = frm_cnt;
            send_byte(tbl[i].data, tbl[i].stop_ok);
            check($sformatf("tbl_cmd[%0d]", i), 32'(cmd), 32'(tbl[i].exp_cmd));
            check($sformatf("tbl_rdy[%0d]", i), 32'(cmd_rdy), 32'(tbl[i].exp_rdy));
            check($sformatf("tbl_ovr[%0d]", i), 32'(ovr_cnt - o0), 32'(tbl[i].exp_ovr));
            check($sformatf("tbl_frm[%0d]", i), 32'(frm_cnt - f0), 32'(tbl[i].exp_frm));
        end

        // response relay
        resp_data = POS_ACK;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        check("resp_trmt", 32'(trmt), 32'h1);
        check("resp_tx_data", 32'(tx_data), 32'(POS_ACK));
        tick();
        check("resp_trmt_1cyc", 32'(trmt), 32'h0);
        resp_data = NEG_ACK;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        check("resp_busy_trmt", 32'(trmt), 32'h0);
        check("resp_busy_data", 32'(tx_data), 32'(POS_ACK));
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("resp_sent", 32'(resp_sent), 32'h1);
        tick();
        check("resp_sent_1cyc", 32'(resp_sent), 32'h0);
        check("resp_trmt_count", 32'(trmt_cnt), 32'h1);
        check("resp_sent_count", 32'(sent_cnt), 32'h1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        check("resp_idle_done", 32'(sent_cnt), 32'h1);

        // long gap after byte0
        pulse_clr();
        send_byte(8'h02, 1'b1);
        repeat (c_TO + 10) tick();
        o0 = ovr_cnt;
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'hC8, 1'b1);
`ifdef CMD_TIMEOUT_EN
        check("to_cmd", 32'(cmd), 32'h0304C8);
        check("to_ovr", 32'(ovr_cnt - o0), 32'h0);
`else
        check("gap_cmd", 32'(cmd), 32'h020304);
        check("gap_ovr", 32'(ovr_cnt - o0), 32'h1);
`endif
        check("gap_rdy", 32'(cmd_rdy), 32'h1);

        // reset in the middle of the second byte
        pulse_clr();
        send_byte(8'hAB, 1'b1);
        RX = 1'b0;
        repeat (3 * c_BAUD) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd", 32'(cmd), 32'h0);
        check("mid_rst_rdy", 32'(cmd_rdy), 32'h0);
        check("mid_rst_trmt", 32'(trmt), 32'h0);
        check("mid_rst_tx_data", 32'(tx_data), 32'h0);
        check("mid_rst_sent", 32'(resp_sent), 32'h0);
        check("mid_rst_ovr", 32'(ovr_err), 32'h0);
        check("mid_rst_frm", 32'(frm_err), 32'h0);
        RX = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        send_byte(8'hC3, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h81, 1'b1);
        check("post_rst_cmd", 32'(cmd), 32'hC33C81);
        check("post_rst_rdy", 32'(cmd_rdy), 32'h1);

        // random bytes against the model
        m_pending = 1'b1;
        m_idx     = 0;
        m_cmd     = 24'hC33C81;
        for (int i = 0; i < 40; i++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 9) != 0);
            rc = ($urandom_range(0, 2) == 0);
            if (rc) begin
                pulse_clr();
                model_clr();
            end
            o0 = ovr_cnt;
            f0 = frm_cnt;
            send_byte(rb, rs);
            model_byte(rb, rs, d_ovr, d_frm);
            check($sformatf("rnd_cmd[%0d]", i), 32'(cmd), 32'(m_cmd));
            check($sformatf("rnd_rdy[%0d]", i), 32'(cmd_rdy), 32'(m_pending));
            check($sformatf("rnd_ovr[%0d]", i), 32'(ovr_cnt - o0), 32'(d_ovr));
            check($sformatf("rnd_frm[%0d]", i), 32'(frm_cnt - f0), 32'(d_frm));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_cmd_rx
`default_nettype wire
